// File: rtl/op_seq_pkg.sv
// Shared definitions for the op sequencer: unit IDs, op codes, bank codes,
// command word layout and FSM state encoding.
package op_seq_pkg;

  localparam logic [2:0] UNIT_PD     = 3'd0;
  localparam logic [2:0] UNIT_DECOMP = 3'd1;
  localparam logic [2:0] UNIT_PA     = 3'd2;
  localparam logic [2:0] UNIT_NTT    = 3'd3;
  localparam logic [2:0] UNIT_DEC    = 3'd4;

  localparam logic [1:0] OP_MULT         = 2'd0;
  localparam logic [1:0] OP_ADD          = 2'd1;
  localparam logic [1:0] OP_SUB          = 2'd2;
  localparam logic [1:0] OP_MULT_PRECOMP = 2'd3;

  localparam logic [1:0] BANK_0 = 2'd0;
  localparam logic [1:0] BANK_1 = 2'd1;
  localparam logic [1:0] BANK_2 = 2'd2;
  localparam logic [1:0] BANK_3 = 2'd3;

  localparam int CMD_LAST_BIT = 15;
  localparam int CMD_UNIT_LSB = 12;
  localparam int CMD_OP_LSB   = 10;
  localparam int CMD_BA_LSB   = 8;
  localparam int CMD_BB_LSB   = 6;

  typedef struct packed {
    logic       last;
    logic [2:0] unit;
    logic [1:0] op;
    logic [1:0] bank_a;
    logic [1:0] bank_b;
    logic [5:0] rsvd;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic logic [15:0] cmd_pack(input logic last, input logic [2:0] unit,
                                           input logic [1:0] op, input logic [1:0] bank_a,
                                           input logic [1:0] bank_b);
    logic [15:0] w;
    w = '0;
    w[CMD_LAST_BIT]      = last;
    w[CMD_UNIT_LSB +: 3] = unit;
    w[CMD_OP_LSB +: 2]   = op;
    w[CMD_BA_LSB +: 2]   = bank_a;
    w[CMD_BB_LSB +: 2]   = bank_b;
    return w;
  endfunction

endpackage

// File: rtl/op_prog_mem.sv
// Command memory: DEPTH x DW register file, one write port, registered read.
// Array is never reset so a loaded program survives rst; only the read register clears.
module op_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_dat_q;
  logic [DW-1:0] rd_dat_d;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) rd_dat_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_dat_q <= '0;
    else     rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/op_sequencer.sv
// Programmable sequencer issuing start pulses to poly-RAM units from a command memory.
// Optional watchdog abort enabled by defining OP_SEQ_TIMEOUT_EN.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int NUM_UNITS      = 8,
  parameter int PROG_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int PW            = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 prog_we,
  input  logic [PW-1:0]        prog_addr,
  input  logic [15:0]          prog_di,
  output logic                 busy,
  output logic                 seq_done,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [2:0]           sel_unit,
  output logic [1:0]           op_code,
  output logic [1:0]           bank_a,
  output logic [1:0]           bank_b,
  output logic [PW-1:0]        pc_out,
  output logic                 err
);

  state_e      state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0] cmd_raw;
  cmd_t        cmd;
  logic        rd_en;
  logic        done_hit;
  logic        hold;
  logic        unused_rsvd;

  // The memory read register doubles as the command register.
  op_prog_mem #(.DEPTH(PROG_DEPTH), .AW(PW), .DW(16)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (prog_we && (state_q == ST_IDLE)),
    .wr_addr (prog_addr),
    .wr_dat  (prog_di),
    .rd_en   (rd_en),
    .rd_addr (pc_q),
    .rd_dat  (cmd_raw)
  );

  assign cmd         = cmd_t'(cmd_raw);
  assign unused_rsvd = ^cmd.rsvd;

  always_comb begin
    done_hit   = 1'b0;
    unit_start = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (cmd.unit == 3'(i)) begin
        done_hit      = unit_done[i];
        unit_start[i] = (state_q == ST_ISSUE);
      end
    end
  end

`ifdef OP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_en    = 1'b0;
    seq_done = 1'b0;
`ifdef OP_SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
`ifdef OP_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef OP_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (done_hit) begin
          if (cmd.last || (pc_q == PW'(PROG_DEPTH - 1))) begin
            state_d = ST_FIN;
          end else begin
            pc_d    = pc_q + PW'(1);
            state_d = ST_FETCH;
          end
        end
`ifdef OP_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_FIN: begin
        seq_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
`ifdef OP_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef OP_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef OP_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign hold     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign busy     = (state_q != ST_IDLE);
  assign sel_unit = hold ? cmd.unit   : 3'd0;
  assign op_code  = hold ? cmd.op     : 2'd0;
  assign bank_a   = hold ? cmd.bank_a : 2'd0;
  assign bank_b   = hold ? cmd.bank_b : 2'd0;
  assign pc_out   = pc_q;

endmodule
